// File: rtl/wr_sync_supervisor.sv
// wr_sync_supervisor: brings up a WR master/slave pair, measures slave-minus-master
// PPS skew in clk_sys_i cycles and declares lock/unlock with hysteresis.
module wr_sync_supervisor #(
    parameter int g_link_timeout = 125_000_000,
    parameter int g_pps_timeout  = 250_000_000,
    parameter int g_offset_width = 16,
    parameter int g_lock_thresh  = 2,
    parameter int g_lock_count   = 3,
    parameter int g_unlock_count = 2
) (
    input  logic                             clk_sys_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             link_up_m_i,
    input  logic                             link_up_s_i,
    input  logic                             pps_m_i,
    input  logic                             pps_s_i,
    output logic [2:0]                       state_o,
    output logic                             locked_o,
    output logic signed [g_offset_width-1:0] offset_o,
    output logic                             offset_valid_o,
    output logic                             miss_o,
    output logic                             fault_o,
    output logic [1:0]                       fault_code_o,
    output logic                             slave_rst_o
);
    localparam int W  = g_offset_width;
    localparam int CW = g_offset_width - 1;
    localparam logic [CW-1:0] MAX_C   = CW'(2**(W-1) - 1);
    localparam logic [W-1:0]  THRESH  = W'(g_lock_thresh);
    localparam logic [31:0]   LINK_TO = 32'(g_link_timeout - 1);
    localparam logic [31:0]   PPS_TO  = 32'(g_pps_timeout - 1);
    localparam logic [15:0]   LOCK_N  = 16'(g_lock_count);
    localparam logic [15:0]   ULOCK_N = 16'(g_unlock_count);

    typedef enum logic [2:0] {
        IDLE = 3'd0, WAIT_LINK = 3'd1, WAIT_PPS = 3'd2,
        TRACK = 3'd3, LOCKED = 3'd4, FAULT = 3'd5
    } state_t;

    state_t        state;
    logic          pps_m_d, pps_s_d;
    logic          e_m, e_s, active;
    logic          armed, first_m;
    logic [CW-1:0] cnt, n;
    logic [W-1:0]  mag, abs_off;
    logic          good;
    logic [31:0]   timer, timer_inc;
    logic [15:0]   good_cnt, bad_cnt, good_inc, bad_inc;

    assign state_o   = state;
    assign e_m       = pps_m_i & ~pps_m_d;
    assign e_s       = pps_s_i & ~pps_s_d;
    assign active    = (state == WAIT_PPS) || (state == TRACK) || (state == LOCKED);
    assign n         = cnt + 1'b1;
    assign mag       = {1'b0, n};
    assign abs_off   = offset_o[W-1] ? W'(-offset_o) : W'(offset_o);
    assign good      = !miss_o && (abs_off <= THRESH);
    assign timer_inc = (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;
    assign good_inc  = (good_cnt == 16'hFFFF) ? good_cnt : good_cnt + 16'd1;
    assign bad_inc   = (bad_cnt == 16'hFFFF) ? bad_cnt : bad_cnt + 16'd1;

    // Skew meter: pair master/slave PPS edges and emit one registered sample per pair.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            pps_m_d        <= 1'b0;
            pps_s_d        <= 1'b0;
            armed          <= 1'b0;
            first_m        <= 1'b0;
            cnt            <= '0;
            offset_o       <= '0;
            offset_valid_o <= 1'b0;
            miss_o         <= 1'b0;
        end else begin
            pps_m_d        <= pps_m_i;
            pps_s_d        <= pps_s_i;
            offset_valid_o <= 1'b0;
            miss_o         <= 1'b0;
            if (!active) begin
                armed    <= 1'b0;
                cnt      <= '0;
                offset_o <= '0;
            end else if (!armed) begin
                if (e_m && e_s) begin
                    offset_o       <= '0;
                    offset_valid_o <= 1'b1;
                end else if (e_m || e_s) begin
                    armed   <= 1'b1;
                    first_m <= e_m;
                    cnt     <= '0;
                end
            end else if (first_m ? e_s : e_m) begin
                // partner edge closes the window; a simultaneous same-side edge is dropped
                offset_o       <= first_m ? mag : W'(-mag);
                offset_valid_o <= 1'b1;
                armed          <= 1'b0;
                cnt            <= '0;
            end else if (first_m ? e_m : e_s) begin
                cnt <= '0;
            end else if (n == MAX_C) begin
                offset_o       <= first_m ? mag : W'(-mag);
                offset_valid_o <= 1'b1;
                miss_o         <= 1'b1;
                armed          <= 1'b0;
                cnt            <= '0;
            end else begin
                cnt <= n;
            end
        end
    end

    // Supervisor FSM; locked_o/fault_o follow the next state so they align with state_o.
    always_ff @(posedge clk_sys_i) begin
        state_t nxt;
        if (rst_i) begin
            state        <= IDLE;
            timer        <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            locked_o     <= 1'b0;
            fault_o      <= 1'b0;
            fault_code_o <= 2'd0;
            slave_rst_o  <= 1'b0;
        end else begin
            nxt = state;
            slave_rst_o <= 1'b0;
            if (!enable_i) begin
                nxt = IDLE;
                timer        <= '0;
                fault_code_o <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        nxt = WAIT_LINK;
                        timer <= '0;
                    end
                    WAIT_LINK: begin
                        if (link_up_m_i && link_up_s_i) begin
                            nxt = WAIT_PPS;
                            timer <= '0;
                        end else if (timer >= LINK_TO) begin
                            nxt = FAULT;
                            fault_code_o <= 2'd1;
                            slave_rst_o  <= 1'b1;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    WAIT_PPS, TRACK, LOCKED: begin
                        if (!link_up_m_i || !link_up_s_i) begin
                            nxt = FAULT;
                            fault_code_o <= 2'd2;
                            slave_rst_o  <= 1'b1;
                        end else if (!e_m && timer >= PPS_TO) begin
                            nxt = FAULT;
                            fault_code_o <= 2'd3;
                            slave_rst_o  <= 1'b1;
                        end else begin
                            timer <= e_m ? 32'd0 : timer_inc;
                            if (offset_valid_o) begin
                                if (state == WAIT_PPS) begin
                                    nxt = TRACK;
                                    good_cnt <= good ? 16'd1 : 16'd0;
                                    bad_cnt  <= '0;
                                end else if (state == TRACK) begin
                                    if (good) begin
                                        good_cnt <= good_inc;
                                        if (good_inc >= LOCK_N) begin
                                            nxt = LOCKED;
                                            bad_cnt <= '0;
                                        end
                                    end else begin
                                        good_cnt <= '0;
                                    end
                                end else begin
                                    if (!good) begin
                                        bad_cnt <= bad_inc;
                                        if (bad_inc >= ULOCK_N) begin
                                            nxt = TRACK;
                                            good_cnt <= '0;
                                        end
                                    end else begin
                                        bad_cnt <= '0;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
            state    <= nxt;
            locked_o <= (nxt == LOCKED);
            fault_o  <= (nxt == FAULT);
        end
    end
endmodule
